shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that performs an arbitrary-distance shift (0–15 positions) by iterating the datapath's single-position `shifter` one step per clock. It sits between the instruction decode/FSM and the shifter stage: it accepts a start request with operand, operation and amount, drives the shifter's `in`/`shift` inputs each cycle, feeds the shifter's `sout` back into an internal accumulator, and returns the result with a one-cycle `done` pulse. The shifter itself stays combinational and external; this block only sequences it.

## Interface
- `WIDTH`, 16, data width; must equal the shifter width.
- `AMT_W`, 4, shift-amount width; the maximum distance is 2^AMT_W − 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  operation: 00 pass, 01 LSL, 10 LSR, 11 ASR (same encoding as the shifter's `shift` input).
- `amount`  in  AMT_W  shift distance.
- `din`  in  WIDTH  operand.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; `dout` is valid.
- `dout`  out  WIDTH  result register; holds its value until the next completion.
- `sh_in`  out  WIDTH  to shifter `in`.
- `sh_shift`  out  2  to shifter `shift`.
- `sh_out`  in  WIDTH  from shifter `sout`.

## Operation
- **Registers:** `state` {IDLE, SHIFT, DONE}, `acc[WIDTH]`, `cnt[AMT_W]`, `op_q[2]`, `dout`.
- **Combinational outputs:**
  - `sh_in` = `acc` always.
  - `sh_shift` = `op_q` in SHIFT, otherwise 00.
  - `busy` = (state == SHIFT).
  - `done` = (state == DONE).
- **IDLE or DONE with `start` = 1:**
  - Latch `acc` ← `din`, `cnt` ← `amount`, `op_q` ← `op`.
  - If `amount` == 0 or `op` == 00: `dout` ← `din` and the next state is DONE. The shifter is not stepped.
  - Otherwise the next state is SHIFT.
- **DONE with `start` = 0:** the next state is IDLE.
- **IDLE with `start` = 0:** remain in IDLE.
- **SHIFT, each cycle:**
  - `acc` ← `sh_out`, `cnt` ← `cnt` − 1.
  - When `cnt` == 1 at the edge: `dout` ← `sh_out` and the next state is DONE.
- **`start` while busy:** ignored. It is not queued, and the inputs are not re-sampled.
- **Inputs after acceptance:** `op`, `amount` and `din` may change freely; only the latched copies are used.
- **Arithmetic:**
  - LSL fills with 0 at the LSB.
  - LSR fills with 0 at the MSB.
  - ASR replicates bit WIDTH−1 on every step, so an ASR of 15 yields all sign bits.
  - No wrap or rotate.
  - `cnt` never underflows, because SHIFT is entered only with `cnt` ≥ 1.
- **Reset (`rst_n` = 0, any time, including mid-SHIFT):**
  - `state` = IDLE; `acc`, `cnt`, `op_q`, `dout` = 0.
  - `busy` = 0, `done` = 0, `sh_shift` = 00, `sh_in` = 0.
  - An in-flight operation is discarded; no `done` is produced for it.

## Timing
- Call the accepting edge E0.
- **`amount` == 0 or op 00:** `done` is high during the cycle after E0 (latency 1).
- **`amount` = N ≥ 1 with op ≠ 00:**
  - `busy` is high for exactly N cycles after E0.
  - The shifter is stepped at edges E1..EN.
  - `done` is high during the cycle after EN (latency N + 1 edges from E0).
- `done` is exactly one cycle wide.
- `dout` updates on the same edge that raises `done` and is stable from then until the next completion edge.
- **Back-to-back:** `start` asserted during the DONE cycle is accepted at that edge; there is no idle bubble.
- `sh_out` is combinational from `sh_in`/`sh_shift`, so there is a single-cycle path acc → shifter → acc.

## Test plan
- **Reset:** hold `rst_n` = 0 → all outputs 0 and `sh_shift` = 00. Release, then `start` op 01, amount 4, din 0x0001 → `busy` for 4 cycles, `done` on the 5th cycle after the start edge, `dout` = 0x0010.
- **ASR full sign fill:** op 11, amount 15, din 0x8000 → `dout` = 0xFFFF. With op 11, amount 3, din 0x7F00 → `dout` = 0x0FE0.
- **Degenerate requests:** amount 0, op 01, din 0xABCD → `done` 1 cycle after start, `dout` = 0xABCD, `sh_shift` stays 00. Same result for op 00, amount 9.
- **Ignored and back-to-back starts:**
  - op 10, amount 2, din 0x8001, with `start` re-asserted mid-SHIFT using din 0xFFFF → `dout` = 0x2000 and a single `done`.
  - Then `start` during the DONE cycle with op 01, amount 1, din 0x0003 → `dout` = 0x0006 one edge later.
- **Reset mid-operation:** op 01, amount 10, with `rst_n` pulsed low at step 5 → `busy`/`done` go low immediately, `dout` = 0, no `done` follows. A fresh request then completes normally.
- **Input hold check:** change `din`/`op`/`amount` every cycle during SHIFT → the result depends only on the values latched at E0.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/response and shifter-feedback signals of shift_sequencer.
// slave = the sequencer itself, master = decode/FSM side plus the external shifter.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] sh_in;
  logic [1:0]       sh_shift;
  logic [WIDTH-1:0] sh_out;

  modport slave (
    input  start, op, amount, din, sh_out,
    output busy, done, dout, sh_in, sh_shift
  );

  modport master (
    output start, op, amount, din, sh_out,
    input  busy, done, dout, sh_in, sh_shift
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates an external single-step shifter
// once per clock for 'amount' steps and returns the result with a done pulse.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_d = bus.din;
          cnt_d = bus.amount;
          op_d  = bus.op;
          // Zero distance or pass completes without stepping the shifter.
          if (bus.amount == '0 || bus.op == 2'b00) begin
            dout_d  = bus.din;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = bus.sh_out;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          dout_d  = bus.sh_out;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.sh_in    = acc_q;
  assign bus.sh_shift = (state_q == SHIFT) ? op_q : 2'b00;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.dout     = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer with a closed-form reference model,
// a per-cycle output comparator and a few hand-computed directed cases.
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [3:0]  amount = '0;
  logic [15:0] din = '0;
  int checks = 0;
  int errors = 0;

  shift_sequencer_if #(.WIDTH(16), .AMT_W(4)) bus ();
  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] o,
                                            input int unsigned a);
    logic signed [15:0] s;
    s = d;
    case (o)
      2'b01:   return d << a;
      2'b10:   return d >> a;
      2'b11:   return s >>> a;
      default: return d;
    endcase
  endfunction

  // The external combinational shifter
  assign bus.start  = start;
  assign bus.op     = op;
  assign bus.amount = amount;
  assign bus.din    = din;
  assign bus.sh_out = ref_shift(bus.sh_in, bus.sh_shift, 1);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles, accumulator, latched op, result
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_dout = '0, m_acc = '0, m_res = '0;
  logic [1:0]  m_op = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_dout = '0; m_acc = '0; m_res = '0; m_op = '0;
    end else if (m_left > 0) begin
      m_acc = ref_shift(m_acc, m_op, 1);
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) m_dout = m_res;
    end else if (start) begin
      m_acc = din;
      m_op  = op;
      m_res = ref_shift(din, op, amount);
      if (amount == 0 || op == 2'b00) begin
        m_done = 1'b1;
        m_dout = din;
      end else begin
        m_left = amount;
        m_done = 1'b0;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(m_left > 0));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("dout", 32'(bus.dout), 32'(m_dout));
    chk("sh_in", 32'(bus.sh_in), 32'(m_acc));
    chk("sh_shift", 32'(bus.sh_shift), 32'((m_left > 0) ? m_op : 2'b00));
  end

  // Called #1 after a posedge; returns #1 after the edge that raised done.
  task automatic do_op(input logic [1:0] o, input logic [3:0] a, input logic [15:0] d,
                       input logic [15:0] exp_v, input int unsigned gap, input bit noisy,
                       input string nm);
    int unsigned n, cyc;
    repeat (gap) begin @(posedge clk); #1; end
    start = 1'b1; op = o; amount = a; din = d;
    @(posedge clk); #1;
    start = 1'b0;
    n = (a == 0 || o == 2'b00) ? 0 : a;
    cyc = 0;
    while (!bus.done && cyc < 20) begin
      if (noisy) begin
        start = 1'($urandom); op = 2'($urandom); amount = 4'($urandom); din = 16'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, cyc, n);
    chk({nm, "_dout"}, 32'(bus.dout), 32'(exp_v));
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_shift", 32'(bus.sh_shift), 0);
    chk("rst_shin", 32'(bus.sh_in), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(2'b01, 4'd4, 16'h0001, 16'h0010, 0, 0, "lsl4");
    do_op(2'b11, 4'd15, 16'h8000, 16'hFFFF, 1, 0, "asr15");
    do_op(2'b11, 4'd3, 16'h7F00, 16'h0FE0, 0, 0, "asr3");
    do_op(2'b01, 4'd0, 16'hABCD, 16'hABCD, 2, 0, "amt0");
    do_op(2'b00, 4'd9, 16'hABCD, 16'hABCD, 0, 0, "pass9");

    // Start re-asserted mid-SHIFT is ignored; then back-to-back from DONE
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; amount = 4'd2; din = 16'h8001;
    @(posedge clk); #1;
    din = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ign_done", 32'(bus.done), 1);
    chk("ign_dout", 32'(bus.dout), 32'h2000);
    do_op(2'b01, 4'd1, 16'h0003, 16'h0006, 0, 0, "b2b");

    // Reset in the middle of a long operation
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; amount = 4'd10; din = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_dout", 32'(bus.dout), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    do_op(2'b10, 4'd5, 16'hF000, 16'h0780, 0, 0, "post_rst");

    do_op(2'b01, 4'd6, 16'h0005, 16'h0140, 0, 1, "hold");

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  ro;
      logic [3:0]  ra;
      logic [15:0] rd;
      ro = 2'($urandom); ra = 4'($urandom); rd = 16'($urandom);
      do_op(ro, ra, rd, ref_shift(rd, ro, ra), $urandom_range(0, 2), 1'($urandom), "rand");
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
